// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-stage program counter with link stack.
package pc_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_STEP      = 1;
  localparam int unsigned DEF_RAS_DEPTH = 8;

  typedef logic [DEF_ADDR_W-1:0] addr_t;

  // Next-PC source selected each falling edge
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REL,
    PC_LINK
  } pc_sel_e;

endpackage

// File: rtl/pc_link_unit_if.sv
// Decode-side bundle for pc_link_unit: branch/condition requests in, PC and link-stack status out.
interface pc_link_unit_if #(
  parameter int unsigned ADDR_W    = pc_pkg::DEF_ADDR_W,
  parameter int unsigned RAS_DEPTH = pc_pkg::DEF_RAS_DEPTH
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic                     stall;
  logic                     write_condition;
  logic                     should_branch;
  logic                     should_branch_to_link;
  logic                     is_call;
  logic signed [ADDR_W-1:0] branch_value;
  logic        [ADDR_W-1:0] link_value;
  logic                     clear_errors;
  logic        [ADDR_W-1:0] instruction_address;
  logic        [ADDR_W-1:0] return_address;
  logic        [CNT_W-1:0]  ras_count;
  logic                     ras_overflow;
  logic                     ras_underflow;

  modport master (
    output stall, write_condition, should_branch, should_branch_to_link, is_call,
           branch_value, link_value, clear_errors,
    input  instruction_address, return_address, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, write_condition, should_branch, should_branch_to_link, is_call,
           branch_value, link_value, clear_errors,
    output instruction_address, return_address, ras_count, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/link_stack.sv
// Circular return-address stack: push/pop/replace, newest-wins overwrite when full, sticky error flags.
module link_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               clear_errors,
  input  logic [ADDR_W-1:0]                  push_data,
  input  logic [ADDR_W-1:0]                  fallback,
  output logic [ADDR_W-1:0]                  top_c,
  output logic [$clog2(RAS_DEPTH + 1)-1:0]   count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_n, ptr_inc, ptr_dec, mem_waddr;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              ovf_q, ovf_n, unf_q, unf_n;
  logic              mem_we, empty, full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(RAS_DEPTH));
  assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);

  // ptr_q always addresses the newest entry; the oldest is silently overwritten on wrap
  always_comb begin
    ptr_n     = ptr_q;
    count_n   = count_q;
    ovf_n     = ovf_q;
    unf_n     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    if (enable) begin
      if (clear_errors) begin
        ovf_n = 1'b0;
        unf_n = 1'b0;
      end
      if (push && pop) begin
        mem_we = 1'b1;
        if (empty) begin
          unf_n     = 1'b1;
          ptr_n     = ptr_inc;
          mem_waddr = ptr_inc;
          count_n   = CNT_W'(1);
        end
      end else if (push) begin
        mem_we    = 1'b1;
        ptr_n     = ptr_inc;
        mem_waddr = ptr_inc;
        if (full) ovf_n = 1'b1;
        else      count_n = count_q + CNT_W'(1);
      end else if (pop) begin
        if (empty) begin
          unf_n = 1'b1;
        end else begin
          ptr_n   = ptr_dec;
          count_n = count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_n;
      count_q <= count_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset
  always_ff @(negedge clock) begin
    if (mem_we && !reset) mem[mem_waddr] <= push_data;
  end

  assign top_c     = empty ? fallback : mem[ptr_q];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_link_unit.sv
// Fetch-stage PC register with hold/increment/relative/return select and optional link stack.
// Define PC_RAS_EN to build the internal return-address stack; otherwise returns use link_value.
module pc_link_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       STEP       = DEF_STEP,
  parameter int unsigned       RAS_DEPTH  = DEF_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic          clock,
  input  logic          reset,
  pc_link_unit_if.slave bus
);

  logic [ADDR_W-1:0] pc_q, pc_n, pc_inc, return_c;
  pc_sel_e           sel;
  logic              taken;

  assign taken  = bus.write_condition & bus.should_branch;
  assign pc_inc = pc_q + ADDR_W'(STEP);

  // Priority: stall, then taken branch (return or relative), else sequential
  always_comb begin
    sel = PC_INC;
    if (bus.stall)  sel = PC_HOLD;
    else if (taken) sel = bus.should_branch_to_link ? PC_LINK : PC_REL;
  end

  always_comb begin
    pc_n = pc_q;
    case (sel)
      PC_HOLD: pc_n = pc_q;
      PC_INC:  pc_n = pc_inc;
      PC_REL:  pc_n = pc_q + $unsigned(bus.branch_value);
      PC_LINK: pc_n = return_c;
      default: pc_n = pc_q;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) pc_q <= RESET_ADDR;
    else       pc_q <= pc_n;
  end

  assign bus.instruction_address = pc_q;
  assign bus.return_address      = return_c;

`ifdef PC_RAS_EN
  logic push, pop;

  assign push = taken & bus.is_call;
  assign pop  = taken & bus.should_branch_to_link;

  link_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_link_stack (
    .clock        (clock),
    .reset        (reset),
    .enable       (~bus.stall),
    .push         (push),
    .pop          (pop),
    .clear_errors (bus.clear_errors),
    .push_data    (pc_inc),
    .fallback     (bus.link_value),
    .top_c        (return_c),
    .count        (bus.ras_count),
    .overflow     (bus.ras_overflow),
    .underflow    (bus.ras_underflow)
  );
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = bus.is_call ^ bus.clear_errors;
  assign return_c          = bus.link_value;
  assign bus.ras_count     = '0;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_link_unit.sv
// Self-checking bench for pc_link_unit against a queue-based reference model.
module tb_pc_link_unit;
  import pc_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned VW    = 2 * AW + CW + 2;
  localparam addr_t       LV    = 32'h0000_0999;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_link_unit_if #(.ADDR_W(AW), .RAS_DEPTH(DEPTH)) bus ();

  pc_link_unit #(
    .ADDR_W     (AW),
    .STEP       (1),
    .RAS_DEPTH  (DEPTH),
    .RESET_ADDR (32'h0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int    errors = 0;
  int    checks = 0;
  addr_t m_pc;
  addr_t m_q[$];
  bit    m_ovf, m_unf;

  function automatic logic [VW-1:0] model_view(input addr_t lv);
    addr_t ra;
    ra = (m_q.size() > 0) ? m_q[$] : lv;
    return {m_pc, CW'(m_q.size()), m_ovf, m_unf, ra};
  endfunction

  function automatic logic [VW-1:0] dut_view();
    return {bus.instruction_address, bus.ras_count, bus.ras_overflow, bus.ras_underflow,
            bus.return_address};
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle, let the falling edge commit, advance the model, settle 1 time unit
  task automatic cycle(input bit st, input bit wc, input bit sb, input bit lk, input bit cl,
                       input addr_t bv, input addr_t lv, input bit clr);
    addr_t old, tgt, dropped;
    bit    nu, no;
    bus.stall                 = st;
    bus.write_condition       = wc;
    bus.should_branch         = sb;
    bus.should_branch_to_link = lk;
    bus.is_call               = cl;
    bus.branch_value          = bv;
    bus.link_value            = lv;
    bus.clear_errors          = clr;
    @(negedge clock);
    if (!st) begin
      old = m_pc;
      nu  = 1'b0;
      no  = 1'b0;
      if (wc && sb) begin
        tgt = old + bv;
        if (lk) begin
          tgt = lv;
`ifdef PC_RAS_EN
          if (m_q.size() == 0) nu = 1'b1;
          else begin
            tgt = m_q[$];
            dropped = m_q.pop_back();
          end
`endif
        end
`ifdef PC_RAS_EN
        if (cl) begin
          m_q.push_back(old + 32'd1);
          if (m_q.size() > int'(DEPTH)) begin
            dropped = m_q.pop_front();
            no = 1'b1;
          end
        end
`endif
        m_pc = tgt;
      end else begin
        m_pc = old + 32'd1;
      end
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      m_ovf = m_ovf | no;
      m_unf = m_unf | nu;
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, LV, 1'b0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.stall = 1'b0; bus.write_condition = 1'b0; bus.should_branch = 1'b0;
    bus.should_branch_to_link = 1'b0; bus.is_call = 1'b0; bus.branch_value = '0;
    bus.link_value = LV; bus.clear_errors = 1'b0;
    model_reset();
    @(negedge clock);
    #1;
    checks++;
    if (dut_view() !== {32'h0, CW'(0), 1'b0, 1'b0, LV}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dut_view(), {32'h0, CW'(0), 2'b00, LV});
    end
    #1 reset = 1'b0;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, LV, 1'b0);
    checks++;
    if (bus.instruction_address !== 32'h40) begin
      errors++;
      $display("FAIL reach_0x40: got %h expected %h", bus.instruction_address, 32'h40);
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_view() !== model_view(LV)) begin
      errors++;
      $display("FAIL reset_from_0x40: got %h expected %h", dut_view(), model_view(LV));
    end
    #1 reset = 1'b0;
    repeat (5) idle();
    checks++;
    if (bus.instruction_address !== 32'd5 || dut_view() !== model_view(LV)) begin
      errors++;
      $display("FAIL five_increments: got %h expected %h", dut_view(), model_view(LV));
    end
  endtask

  task automatic test_branch_rel();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, LV, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, LV, 1'b0);
    checks++;
    if (bus.instruction_address !== 32'd6) begin
      errors++;
      $display("FAIL branch_minus4: got %h expected %h", bus.instruction_address, 32'd6);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, LV, 1'b0);
    checks++;
    if (bus.instruction_address !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL branch_to_top: got %h expected %h", bus.instruction_address, 32'hFFFF_FFFF);
    end
    idle();
    checks++;
    if (bus.instruction_address !== 32'h0 || dut_view() !== model_view(LV)) begin
      errors++;
      $display("FAIL increment_wrap: got %h expected %h", dut_view(), model_view(LV));
    end
  endtask

  task automatic test_call_return();
    addr_t exp_ret;
`ifdef PC_RAS_EN
    exp_ret = 32'h11;
`else
    exp_ret = LV;
`endif
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, LV, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, LV, 1'b0);
    checks++;
    if (bus.instruction_address !== 32'h30 || bus.return_address !== exp_ret) begin
      errors++;
      $display("FAIL call_0x10: got pc %h top %h expected pc %h top %h",
               bus.instruction_address, bus.return_address, 32'h30, exp_ret);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, LV, 1'b0);
    checks++;
    if (bus.instruction_address !== exp_ret || bus.ras_count !== CW'(0)
        || dut_view() !== model_view(LV)) begin
      errors++;
      $display("FAIL return_0x11: got %h expected %h", dut_view(), model_view(LV));
    end
  endtask

  task automatic test_overflow_underflow();
    logic [CW-1:0] exp_cnt;
    bit            exp_flag;
`ifdef PC_RAS_EN
    exp_cnt  = CW'(DEPTH);
    exp_flag = 1'b1;
`else
    exp_cnt  = '0;
    exp_flag = 1'b0;
`endif
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2, LV, 1'b0);
      checks++;
      if (dut_view() !== model_view(LV)) begin
        errors++;
        $display("FAIL nested_call_%0d: got %h expected %h", i, dut_view(), model_view(LV));
      end
    end
    checks++;
    if (bus.ras_count !== exp_cnt || bus.ras_overflow !== exp_flag) begin
      errors++;
      $display("FAIL overflow_state: got cnt %0d ovf %b expected cnt %0d ovf %b",
               bus.ras_count, bus.ras_overflow, exp_cnt, exp_flag);
    end
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, LV, 1'b0);
      checks++;
      if (dut_view() !== model_view(LV)) begin
        errors++;
        $display("FAIL nested_return_%0d: got %h expected %h", i, dut_view(), model_view(LV));
      end
    end
    checks++;
    if (bus.instruction_address !== LV || bus.ras_underflow !== exp_flag
        || bus.ras_count !== CW'(0)) begin
      errors++;
      $display("FAIL underflow_state: got pc %h unf %b expected pc %h unf %b",
               bus.instruction_address, bus.ras_underflow, LV, exp_flag);
    end
  endtask

  task automatic test_clear_errors();
    bit exp_unf;
`ifdef PC_RAS_EN
    exp_unf = 1'b1;
`else
    exp_unf = 1'b0;
`endif
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, LV, 1'b1);
    checks++;
    if (bus.ras_overflow !== 1'b0 || bus.ras_underflow !== exp_unf
        || dut_view() !== model_view(LV)) begin
      errors++;
      $display("FAIL clear_vs_new_error: got %h expected %h", dut_view(), model_view(LV));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, LV, 1'b1);
    checks++;
    if (bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_only: got ovf %b unf %b expected 0 0", bus.ras_overflow, bus.ras_underflow);
    end
  endtask

  task automatic test_stall();
    addr_t pc_before;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd7, LV, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd7, LV, 1'b0);
    pc_before = m_pc;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, LV, 1'b1);
      checks++;
      if (bus.instruction_address !== pc_before || dut_view() !== model_view(LV)) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, dut_view(), model_view(LV));
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, LV, 1'b0);
    checks++;
    if (bus.instruction_address !== pc_before + 32'd1 || dut_view() !== model_view(LV)) begin
      errors++;
      $display("FAIL not_taken_inc: got %h expected %h", dut_view(), model_view(LV));
    end
  endtask

  task automatic test_async_reset();
    logic [CW-1:0] exp_cnt;
`ifdef PC_RAS_EN
    exp_cnt = CW'(3);
`else
    exp_cnt = '0;
`endif
    pulse_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, LV, 1'b0);
    checks++;
    if (bus.ras_count !== exp_cnt) begin
      errors++;
      $display("FAIL three_calls_count: got %0d expected %0d", bus.ras_count, exp_cnt);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_view() !== {32'h0, CW'(0), 1'b0, 1'b0, LV}) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", dut_view(), {32'h0, CW'(0), 2'b00, LV});
    end
    #1 reset = 1'b0;
    idle();
    checks++;
    if (bus.instruction_address !== 32'd1 || dut_view() !== model_view(LV)) begin
      errors++;
      $display("FAIL first_inc_after_reset: got %h expected %h", dut_view(), model_view(LV));
    end
  endtask

  task automatic test_random();
    logic [7:0] r8;
    addr_t      bv, lv;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      r8 = 8'($urandom);
      bv = ($urandom_range(0, 9) == 0) ? addr_t'($urandom) : {{24{r8[7]}}, r8};
      lv = ($urandom_range(0, 1) == 0) ? LV : addr_t'($urandom);
      cycle($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            bv, lv, $urandom_range(0, 15) == 0);
      checks++;
      if (dut_view() !== model_view(lv)) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", i, dut_view(), model_view(lv));
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch_rel();
    test_call_return();
    test_overflow_underflow();
    test_clear_errors();
    test_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_link_unit.md
# pc_link_unit

Parametrised program-counter unit with an internal return-address (link) stack, for the processor's fetch stage. Each cycle it holds, increments, branches PC-relative, or returns to a link address. Call branches push the return address automatically, so nested calls no longer depend on a single external link register. Its output drives the instruction-memory address; its branch and condition inputs come from the decode/condition logic.

## Interface
Parameters:
- ADDR_W, 32: width of instruction_address, branch_value, link_value.
- STEP, 1: increment per sequential instruction (word-addressed memory).
- RAS_DEPTH, 8: link-stack entries, ≥2.
- RESET_ADDR, 0: address loaded on reset.

Ports:
- clock  in  1: single clock; state updates on the falling edge.
- reset  in  1: asynchronous, active-high.
- stall  in  1: hold PC and stack this cycle.
- write_condition  in  1: condition-pass qualifier.
- should_branch  in  1: branch request.
- should_branch_to_link  in  1: branch is a return.
- is_call  in  1: branch also pushes its return address.
- branch_value  in  ADDR_W signed: PC-relative offset.
- link_value  in  ADDR_W: fallback return target.
- clear_errors  in  1: clears the sticky flags.
- instruction_address  out  ADDR_W: current PC.
- return_address  out  ADDR_W: stack top, or link_value when the stack is empty.
- ras_count  out  $clog2(RAS_DEPTH+1): occupied entries.
- ras_overflow  out  1: sticky; a push was made when the stack was full.
- ras_underflow  out  1: sticky; a pop was made when the stack was empty.

## Operation
- taken = write_condition & should_branch.
- Priority: reset > stall > taken > increment.
- Increment: PC ← PC + STEP, modulo 2^ADDR_W.
- Taken, non-return: PC ← PC + sign-extended branch_value, wrapping modulo 2^ADDR_W. If is_call, push PC + STEP.
- Taken, return: PC ← return_address, and pop.
  - Empty stack: target is link_value, ras_count stays 0, ras_underflow is set.
- Return with is_call: pop and push happen in the same cycle, so the top entry is replaced with PC + STEP and ras_count is unchanged.
- Push when full: circular overwrite of the oldest entry, ras_count stays RAS_DEPTH, ras_overflow is set.
  - A later pop returns the newest entries. Once the stack drains, the overwritten entry is lost.
- is_call without taken: ignored.
- Stall: PC, stack, count and flags all hold. Branch, push and pop are discarded, not queued.
- clear_errors: clears both flags on the next edge. A simultaneous new error wins, and the flag stays set.

## Timing
- Reset (asynchronous) values:
  - instruction_address = RESET_ADDR.
  - ras_count = 0.
  - Both flags = 0.
  - Stack contents are don't-care.
  - return_address = link_value.
- Reset asserted mid-sequence aborts any pending push or pop immediately.
- First increment occurs on the first falling edge after reset deasserts.
- All inputs are sampled on the falling edge; the new PC is visible from that edge, so branch-to-address latency is 1 cycle.
- return_address is combinational from registered stack state plus link_value. It reflects the state before the current edge.
- No handshake: every non-stalled cycle commits exactly one PC update.

## Configuration
- PC_RAS_EN defined: the internal link stack is as described above.
- PC_RAS_EN undefined: no stack storage is built.
  - return_address = link_value.
  - Returns branch to link_value.
  - ras_count is tied to 0 and both flags are tied to 0.
  - is_call is ignored.
  - The block reduces to a parametrised PC with stall.

## Structure
- Shared package pc_pkg holds:
  - Default ADDR_W, STEP and RAS_DEPTH constants.
  - The typedef addr_t = logic [ADDR_W-1:0].
  - An enum for next-PC select: PC_HOLD, PC_INC, PC_REL, PC_LINK.
- One sub-module, link_stack: a circular buffer with push/pop/replace, top, count and flags, instantiated only under PC_RAS_EN.
- The top level holds the PC register and next-PC mux.

## Test plan
- Reset at PC 0x40 → PC = 0x0, ras_count 0. Five unstalled cycles → PC = 5.
- At PC 10, branch_value = −4 taken → PC 6. At PC 2^32−1 with no branch → wraps to 0.
- Call at PC 0x10, offset +0x20 → PC 0x30, top 0x11. Return → PC 0x11, ras_count 0.
- Nine nested calls with RAS_DEPTH 8 → ras_overflow = 1, ras_count 8. Nine returns → last return uses link_value, ras_underflow = 1.
- Stall held 3 cycles during a taken call → PC and ras_count unchanged. should_branch with write_condition = 0 → PC + 1.
- Reset asserted between edges while ras_count = 3 → outputs reset immediately, without waiting for a clock edge.
